// File: rtl/dm_lane_mem_pkg.sv
// Shared load-kind codes, controller states and lane helpers for the M-stage data memory.
package mem_pkg;

   localparam logic [2:0] LD_NONE = 3'd0;
   localparam logic [2:0] LD_W    = 3'd1;
   localparam logic [2:0] LD_H    = 3'd2;
   localparam logic [2:0] LD_HU   = 3'd3;
   localparam logic [2:0] LD_B    = 3'd4;
   localparam logic [2:0] LD_BU   = 3'd5;

   typedef enum logic {
      CLEAR,
      RUN
   } memState_t;

   // Expands the 4-bit byte enable into a 32-bit bit mask, one byte per lane.
   function automatic logic [31:0] laneMask(input logic [3:0] be);
      return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
   endfunction

endpackage

// File: rtl/dm_lane_mem_load_ext.sv
// Load lane selection with sign or zero extension of the raw memory word.
module load_ext
   import mem_pkg::*;
(
   input  logic [31:0] rd_i,
   input  logic [1:0]  addrLo_i,
   input  logic [2:0]  ldType_i,
   output logic [31:0] value_o
);

   logic [15:0] halfSel;
   logic [7:0]  byteSel;

   always_comb begin
      halfSel = addrLo_i[1] ? rd_i[31:16] : rd_i[15:0];
      byteSel = rd_i[{addrLo_i, 3'b000} +: 8];
      value_o = '0;
      case (ldType_i)
         LD_W:    value_o = rd_i;
         LD_H:    value_o = {{16{halfSel[15]}}, halfSel};
         LD_HU:   value_o = {16'h0000, halfSel};
         LD_B:    value_o = {{24{byteSel[7]}}, byteSel};
         LD_BU:   value_o = {24'h000000, byteSel};
         default: value_o = '0;
      endcase
   end

endmodule

// File: rtl/dm_lane_mem.sv
// M-stage data memory: byte-lane stores, extended word loads, a write log for the bench
// and a post-reset sweep that zeroes every word before accepting traffic.
module dm_lane_mem
   import mem_pkg::*;
#(
   parameter int WORDS = 3072,
   parameter int AW    = 12
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        en,
   input  logic [31:0] addr,
   input  logic [3:0]  byteen,
   input  logic [31:0] wdata,
   input  logic [2:0]  ld_type,
   input  logic [31:0] pc,
   output logic        busy,
   output logic [31:0] w_rdata,
   output logic        addr_err,
   output logic        wlog_valid,
   output logic [31:0] wlog_pc,
   output logic [31:0] wlog_addr,
   output logic [31:0] wlog_data
);

   localparam logic [31:0]   BYTE_LIMIT = 32'(4 * WORDS);
   localparam logic [AW-1:0] LAST_IDX   = AW'(WORDS - 1);

   logic [31:0] mem [WORDS];

   memState_t   state_q;
   logic [AW-1:0] clrIdx_q;
   logic        busy_q;
   logic        addrErr_q, addrErr_d;
   logic        wlogValid_q;
   logic [31:0] rdata_q, rdata_d;
   logic [31:0] wlogPc_q, wlogAddr_q, wlogData_q;

   logic          inRange;
   logic [AW-1:0] idx;
   logic [31:0]   rdWord, loadVal, mergedWord;
   logic          isStore, isLoad, doWrite;
   logic          memWe;
   logic [AW-1:0] memIdx;
   logic [31:0]   memData;

   assign inRange    = addr < BYTE_LIMIT;
   assign idx        = addr[AW+1:2];
   assign rdWord     = inRange ? mem[idx] : '0;
   assign isStore    = byteen != 4'b0000;
   assign isLoad     = ld_type != LD_NONE;
   assign doWrite    = (state_q == RUN) && en && inRange && isStore;
   assign mergedWord = (rdWord & ~laneMask(byteen)) | (wdata & laneMask(byteen));

   load_ext uLoadExt (
      .rd_i    (rdWord),
      .addrLo_i(addr[1:0]),
      .ldType_i(ld_type),
      .value_o (loadVal)
   );

   // Single write port shared between the clear sweep and normal stores.
   always_comb begin
      memWe   = 1'b0;
      memIdx  = idx;
      memData = mergedWord;
      if (state_q == CLEAR) begin
         memWe   = reset;
         memIdx  = clrIdx_q;
         memData = '0;
      end else if (doWrite && reset) begin
         memWe = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (memWe) begin
         mem[memIdx] <= memData;
      end
   end

   always_comb begin
      rdata_d   = inRange ? loadVal : '0;
      addrErr_d = !inRange && (isStore || isLoad);
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q     <= CLEAR;
         clrIdx_q    <= '0;
         busy_q      <= 1'b1;
         addrErr_q   <= 1'b0;
         wlogValid_q <= 1'b0;
         rdata_q     <= '0;
         wlogPc_q    <= '0;
         wlogAddr_q  <= '0;
         wlogData_q  <= '0;
      end else begin
         unique case (state_q)
            CLEAR: begin
               wlogValid_q <= 1'b0;
               addrErr_q   <= 1'b0;
               if (clrIdx_q == LAST_IDX) begin
                  state_q <= RUN;
                  busy_q  <= 1'b0;
               end else begin
                  clrIdx_q <= clrIdx_q + 1'b1;
               end
            end
            RUN: begin
               wlogValid_q <= doWrite;
               if (en) begin
                  rdata_q   <= rdata_d;
                  addrErr_q <= addrErr_d;
               end
               if (doWrite) begin
                  wlogPc_q   <= pc;
                  wlogAddr_q <= {addr[31:2], 2'b00};
                  wlogData_q <= mergedWord;
               end
            end
         endcase
      end
   end

   assign busy       = busy_q;
   assign w_rdata    = rdata_q;
   assign addr_err   = addrErr_q;
   assign wlog_valid = wlogValid_q;
   assign wlog_pc    = wlogPc_q;
   assign wlog_addr  = wlogAddr_q;
   assign wlog_data  = wlogData_q;

endmodule

// File: doc/dm_lane_mem.md
Name: dm_lane_mem

Overview:
- M-stage data memory; sits directly downstream of the store byte-enable stage and consumes its lane-aligned write word and 4-bit byteen.
- Performs byte-lane writes and word reads with load selection and extension.
- Registers the load result into the M/W boundary and emits a one-cycle write-log record for the testbench.
- After reset, clears its array with a counter-driven sweep.

Parameters:
- WORDS, 3072, number of 32-bit words; valid byte address window is [0, 4*WORDS).
- AW, 12, word-index width; must satisfy 2^AW >= WORDS.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset
- en  in  1  M->W advance; writes, read capture and log are gated by en
- addr  in  32  byte address (ALU result)
- byteen  in  4  lane write enables; 0000 = no store
- wdata  in  32  lane-aligned store data
- ld_type  in  3  load kind; package constants
- pc  in  32  PC of the M-stage instruction, used for logging
- busy  out  1  high while the clear sweep runs; upstream stalls on it
- w_rdata  out  32  registered, extended load result
- addr_err  out  1  registered; previous access was out of range
- wlog_valid  out  1  registered; a write committed last cycle
- wlog_pc  out  32  PC of the committed store
- wlog_addr  out  32  word-aligned address of the committed store ({addr[31:2],2'b00})
- wlog_data  out  32  full merged word after the write

Behaviour:
- Reset (reset==0 at a posedge):
  - State goes to CLEAR and clr_idx goes to 0.
  - w_rdata, wlog_pc, wlog_addr and wlog_data go to 0.
  - addr_err and wlog_valid go to 0; busy goes to 1.
  - Reset asserted mid-sweep restarts the sweep from index 0.
- CLEAR state:
  - Each cycle writes mem[clr_idx]=0 and increments clr_idx.
  - After writing index WORDS-1, goes to RUN; busy drops the same edge.
  - The sweep takes exactly WORDS cycles after reset deassertion.
  - Every functional input is ignored; wlog_valid and addr_err stay 0.
- RUN state, in_range = (addr < 4*WORDS), idx = addr[AW+1:2]:
  - Write condition: en && in_range && byteen!=0. mem[idx] lane k takes wdata lane k for each byteen[k]=1; all other lanes are kept.
  - Write log: on the next edge, wlog_valid=1, wlog_pc=pc, wlog_addr=aligned addr, wlog_data=merged word. Otherwise wlog_valid=0; the other log fields hold.
  - Read: word rd=mem[idx] is read combinationally as pre-write contents. Selection and extension by ld_type:
    - LD_W: rd
    - LD_H / LD_HU: half selected by addr[1] (0 = bits 15:0), sign- or zero-extended
    - LD_B / LD_BU: byte selected by addr[1:0], sign- or zero-extended
    - LD_NONE: 0
  - w_rdata is loaded with this value when en=1 and holds when en=0.
  - Out-of-range with a store or load, and en=1: no write, w_rdata=0, addr_err=1 next cycle. In all other en=1 cycles addr_err=0.
  - Load latency: one clock. The result is valid on w_rdata the cycle after the M-stage cycle.
  - Simultaneous byteen!=0 and ld_type!=LD_NONE is illegal upstream. If it occurs, the write happens and w_rdata carries the pre-write word.
  - Misaligned low address bits on LD_W are ignored (word access).
  - addr bits above the window are checked only through in_range; there is no aliasing.
  - en=0: no write, no log, and all outputs hold except wlog_valid, which goes to 0.

Decomposition:
- Shared package mem_pkg holds:
  - LD_NONE=0, LD_W=1, LD_H=2, LD_HU=3, LD_B=4, LD_BU=5
  - state enum {CLEAR, RUN}
- One natural sub-module, load_ext: a combinational lane select plus sign/zero extend taking (rd, addr[1:0], ld_type).

Test Plan:
- Reset low 2 cycles, then high → busy=1 for exactly 3072 cycles, then 0. A LD_W at 0x100 afterwards returns 0x00000000.
- Store 0x12345678, byteen=1111, addr 0x8, then LD_W at 0x8 → w_rdata=0x12345678 one cycle later. The log shows wlog_valid=1, wlog_addr=0x8, wlog_data=0x12345678, wlog_pc equal to the driven pc.
- Over that word, store wdata=0x00AB0000 with byteen=0100 at addr 0xA:
  - wlog_data=0x12AB5678.
  - LD_B at 0xA gives 0xFFFFFFAB; LD_BU gives 0x000000AB.
- Store wdata=0x80010000 with byteen=1100 at addr 0x12:
  - LD_H at 0x12 gives 0xFFFF8001; LD_HU gives 0x00008001.
  - LD_H at 0x10 gives 0x00000000.
- Store with byteen=1111 at addr 0x3000:
  - No write and wlog_valid=0; addr_err=1 next cycle.
  - A LD_W at 0x3000 gives w_rdata=0 and addr_err=1.
- Deassert reset, wait 100 cycles, assert reset 1 cycle, release → busy stays high for a full 3072 cycles from the second release. Hold en=0 with byteen=1111 → no write, w_rdata unchanged.
